// File: rtl/lfsr_tpg_pkg.sv
// Shared types and the LFSR successor function for lfsr_tpg.
package lfsr_tpg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } tpg_state_e;

  // Operates on a 32-bit container; width selects how many low bits are live.
  function automatic logic [31:0] lfsr_next(input logic [31:0] state,
                                            input logic [31:0] taps,
                                            input logic        galois,
                                            input int unsigned width = 32);
    logic [31:0] mask;
    logic [31:0] nxt;
    logic        fb;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    fb   = 1'b0;
    if (galois) begin
      nxt = ((state & mask) >> 1) ^ (state[0] ? (taps & mask) : '0);
    end else begin
      fb  = ^(state & taps & mask);
      nxt = (state << 1) | {31'd0, fb};
    end
    return nxt & mask;
  endfunction

endpackage

// File: rtl/lfsr_tpg_if.sv
// Pattern generator bus: controller drives en/start/ld/seed_in, generator drives q/valid/done/lockup.
interface lfsr_tpg_if #(
  parameter int unsigned WIDTH = 8
);
  logic             en;
  logic             start;
  logic             ld;
  logic [WIDTH-1:0] seed_in;
  logic [WIDTH-1:0] q;
  logic             valid;
  logic             done;
  logic             lockup;

  modport master (
    output en, start, ld, seed_in,
    input  q, valid, done, lockup
  );

  modport slave (
    input  en, start, ld, seed_in,
    output q, valid, done, lockup
  );
endinterface

// File: rtl/lfsr_tpg_core.sv
// LFSR state register with seed load and all-zero lockup recovery.
// Ports: clk, set (async active-low reset), step, ld, seed_in -> q, lockup.
module lfsr_core
  import lfsr_tpg_pkg::*;
#(
  parameter int unsigned      WIDTH        = 8,
  parameter logic [WIDTH-1:0] TAPS         = WIDTH'(8'hB8),
  parameter bit               GALOIS       = 1'b0,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = '1
) (
  input  logic             clk,
  input  logic             set,
  input  logic             step,
  input  logic             ld,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] q,
  output logic             lockup
);

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] cand;
  logic             upd;

  always_comb begin
    cand = state;
    upd  = 1'b0;
    if (ld) begin
      cand = seed_in;
      upd  = 1'b1;
    end else if (step) begin
      cand = WIDTH'(lfsr_next(32'(state), 32'(TAPS), GALOIS, WIDTH));
      upd  = 1'b1;
    end
  end

  // Zero is absorbing for both forms, so any update that would land there reseeds instead.
  always_ff @(posedge clk or negedge set) begin
    if (!set) begin
      state  <= DEFAULT_SEED;
      lockup <= 1'b0;
    end else begin
      lockup <= 1'b0;
      if (upd) begin
        if (cand == '0) begin
          state  <= DEFAULT_SEED;
          lockup <= 1'b1;
        end else begin
          state <= cand;
        end
      end
    end
  end

  assign q = state;

endmodule

// File: rtl/lfsr_tpg.sv
// Test pattern generator: run FSM and pattern counter around lfsr_core.
// Ports: clk, set (async active-low reset), bus (lfsr_tpg_if slave).
module lfsr_tpg
  import lfsr_tpg_pkg::*;
#(
  parameter int unsigned      WIDTH        = 8,
  parameter logic [WIDTH-1:0] TAPS         = WIDTH'(8'hB8),
  parameter bit               GALOIS       = 1'b0,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = '1,
  parameter int unsigned      NUM_PATTERNS = 255
) (
  input  logic        clk,
  input  logic        set,
  lfsr_tpg_if.slave   bus
);

  localparam int unsigned    CW   = $clog2(NUM_PATTERNS + 1);
  localparam logic [CW-1:0]  LAST = CW'(NUM_PATTERNS - 1);

  tpg_state_e       st;
  tpg_state_e       st_nxt;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             step;
  logic [WIDTH-1:0] q;
  logic             lockup;

  always_ff @(posedge clk or negedge set) begin
    if (!set) begin
      st    <= IDLE;
      count <= '0;
    end else begin
      st    <= st_nxt;
      count <= count_nxt;
    end
  end

  // ld outranks start, start outranks stepping; start never advances the state.
  always_comb begin
    st_nxt    = st;
    count_nxt = count;
    step      = 1'b0;
    if (bus.ld) begin
      st_nxt    = IDLE;
      count_nxt = '0;
    end else if (bus.start) begin
      st_nxt    = RUN;
      count_nxt = '0;
    end else if ((st == RUN) && bus.en) begin
      step = 1'b1;
      if (count == LAST) begin
        st_nxt = DONE;
      end else begin
        count_nxt = count + 1'b1;
      end
    end
  end

  lfsr_core #(
    .WIDTH        (WIDTH),
    .TAPS         (TAPS),
    .GALOIS       (GALOIS),
    .DEFAULT_SEED (DEFAULT_SEED)
  ) u_core (
    .clk     (clk),
    .set     (set),
    .step    (step),
    .ld      (bus.ld),
    .seed_in (bus.seed_in),
    .q       (q),
    .lockup  (lockup)
  );

  assign bus.q      = q;
  assign bus.valid  = (st == RUN);
  assign bus.done   = (st == DONE);
  assign bus.lockup = lockup;

endmodule

// File: tb/tb_lfsr_tpg.sv
module tb_lfsr_tpg;
  import lfsr_tpg_pkg::*;

  typedef struct {
    int unsigned w;
    logic [31:0] taps;
    bit          gal;
    int unsigned num;
  } cfg_t;

  typedef struct {
    logic [31:0] s;
    bit          run;
    bit          dn;
    int unsigned cnt;
    bit          lk;
  } mdl_t;

  logic clk = 1'b0;
  logic set_n = 1'b1;
  always #5 clk = ~clk;

  int unsigned sel = 0;
  logic        en_d = 1'b0;
  logic        start_d = 1'b0;
  logic        ld_d = 1'b0;
  logic [7:0]  seed_d = 8'h00;

  lfsr_tpg_if #(.WIDTH(8)) bus_f ();
  lfsr_tpg_if #(.WIDTH(8)) bus_g ();
  lfsr_tpg_if #(.WIDTH(8)) bus_s ();

  assign bus_f.en = en_d & (sel == 0);
  assign bus_f.start = start_d & (sel == 0);
  assign bus_f.ld = ld_d & (sel == 0);
  assign bus_f.seed_in = seed_d;
  assign bus_g.en = en_d & (sel == 1);
  assign bus_g.start = start_d & (sel == 1);
  assign bus_g.ld = ld_d & (sel == 1);
  assign bus_g.seed_in = seed_d;
  assign bus_s.en = en_d & (sel == 2);
  assign bus_s.start = start_d & (sel == 2);
  assign bus_s.ld = ld_d & (sel == 2);
  assign bus_s.seed_in = seed_d;

  lfsr_tpg #(.WIDTH(8), .TAPS(8'hB8), .GALOIS(1'b0), .DEFAULT_SEED(8'hFF), .NUM_PATTERNS(255))
    dut_f (.clk(clk), .set(set_n), .bus(bus_f));
  lfsr_tpg #(.WIDTH(8), .TAPS(8'hB8), .GALOIS(1'b1), .DEFAULT_SEED(8'hFF), .NUM_PATTERNS(255))
    dut_g (.clk(clk), .set(set_n), .bus(bus_g));
  lfsr_tpg #(.WIDTH(8), .TAPS(8'hB8), .GALOIS(1'b0), .DEFAULT_SEED(8'hFF), .NUM_PATTERNS(4))
    dut_s (.clk(clk), .set(set_n), .bus(bus_s));

  logic [7:0] q_o;
  logic       valid_o, done_o, lockup_o;
  always_comb begin
    q_o = bus_f.q; valid_o = bus_f.valid; done_o = bus_f.done; lockup_o = bus_f.lockup;
    if (sel == 1) begin
      q_o = bus_g.q; valid_o = bus_g.valid; done_o = bus_g.done; lockup_o = bus_g.lockup;
    end else if (sel == 2) begin
      q_o = bus_s.q; valid_o = bus_s.valid; done_o = bus_s.done; lockup_o = bus_s.lockup;
    end
  end

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  cfg_t cfg[3];
  mdl_t m[3];

  function automatic logic [31:0] all_ones(input cfg_t c);
    return 32'((64'd1 << c.w) - 64'd1);
  endfunction

  // Successor from the textbook definitions: shift-and-parity, or halve and fold taps on a dropped one.
  function automatic logic [31:0] ref_step(input cfg_t c, input logic [31:0] s);
    longint unsigned span;
    longint unsigned v;
    int              par;
    span = 64'd1 << c.w;
    if (c.gal) begin
      v = 64'(s) / 64'd2;
      if ((s % 32'd2) == 32'd1) v = v ^ 64'(c.taps);
    end else begin
      par = $countones(s & c.taps) % 2;
      v = (64'(s) * 64'd2 + 64'(par)) % span;
    end
    return 32'(v);
  endfunction

  function automatic mdl_t ref_reset(input cfg_t c);
    mdl_t r;
    r.s = all_ones(c); r.run = 1'b0; r.dn = 1'b0; r.cnt = 0; r.lk = 1'b0;
    return r;
  endfunction

  function automatic mdl_t ref_clock(input cfg_t c, input mdl_t cur, input bit en, input bit start,
                                     input bit ld, input logic [31:0] seed);
    mdl_t n;
    bit   moved;
    n = cur;
    n.lk = 1'b0;
    moved = 1'b0;
    if (ld) begin
      n.s = seed; n.run = 1'b0; n.dn = 1'b0; n.cnt = 0; moved = 1'b1;
    end else if (start) begin
      n.run = 1'b1; n.dn = 1'b0; n.cnt = 0;
    end else if (cur.run && en) begin
      n.s = ref_step(c, cur.s);
      n.cnt = cur.cnt + 1;
      moved = 1'b1;
      if (n.cnt == c.num) begin
        n.run = 1'b0; n.dn = 1'b1;
      end
    end
    if (moved && n.s == 32'd0) begin
      n.s = all_ones(c); n.lk = 1'b1;
    end
    return n;
  endfunction

  task automatic cycle(input bit en, input bit start, input bit ld, input logic [7:0] seed);
    en_d = en; start_d = start; ld_d = ld; seed_d = seed;
    @(posedge clk);
    for (int unsigned i = 0; i < 3; i++)
      m[i] = ref_clock(cfg[i], m[i], (sel == i) && en, (sel == i) && start, (sel == i) && ld, 32'(seed));
    #1;
    en_d = 1'b0; start_d = 1'b0; ld_d = 1'b0;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_q"}, 32'(q_o), m[sel].s);
    check({tag, "_valid"}, 32'(valid_o), 32'(m[sel].run));
    check({tag, "_done"}, 32'(done_o), 32'(m[sel].dn));
    check({tag, "_lockup"}, 32'(lockup_o), 32'(m[sel].lk));
  endtask

  logic [7:0] fib_seq[5] = '{8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE1};
  bit         en_pat[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    bit          seen[256];
    int unsigned distinct;
    int unsigned period;
    int unsigned nvalid;
    logic [7:0]  frozen;
    logic [31:0] rs;

    cfg[0] = '{w: 8, taps: 32'hB8, gal: 1'b0, num: 255};
    cfg[1] = '{w: 8, taps: 32'hB8, gal: 1'b1, num: 255};
    cfg[2] = '{w: 8, taps: 32'hB8, gal: 1'b0, num: 4};
    for (int unsigned i = 0; i < 3; i++) m[i] = ref_reset(cfg[i]);

    #1 set_n = 1'b0;
    #11;
    for (int unsigned i = 0; i < 3; i++) begin
      sel = i;
      #0;
      check("rst_q", 32'(q_o), 32'hFF);
      check("rst_valid", 32'(valid_o), 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_lockup", 32'(lockup_o), 32'd0);
    end
    @(negedge clk) set_n = 1'b1;

    // Fibonacci full run
    sel = 0;
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    check_model("fib_start");
    check("fib_first_q", 32'(q_o), 32'hFF);
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    distinct = 0;
    for (int k = 0; k < 255; k++) begin
      if (valid_o && !seen[q_o]) begin
        seen[q_o] = 1'b1;
        distinct++;
      end
      cycle(1'b1, 1'b0, 1'b0, 8'h00);
      check_model($sformatf("fib_run%0d", k));
      if (k < 5) check($sformatf("fib_seq%0d", k), 32'(q_o), 32'(fib_seq[k]));
    end
    check("fib_distinct", distinct, 32'd255);
    check("fib_no_zero", 32'(seen[0]), 32'd0);
    check("fib_wrap_q", 32'(q_o), 32'hFF);
    check("fib_done", 32'(done_o), 32'd1);
    check("fib_done_valid", 32'(valid_o), 32'd0);
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 8'h00);
    check("fib_frozen_q", 32'(q_o), 32'hFF);
    check("fib_frozen_done", 32'(done_o), 32'd1);

    // Reset in the middle of a run
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    repeat (100) cycle(1'b1, 1'b0, 1'b0, 8'h00);
    check_model("pre_rst");
    check("pre_rst_valid", 32'(valid_o), 32'd1);
    #2 set_n = 1'b0;
    #1;
    for (int unsigned i = 0; i < 3; i++) m[i] = ref_reset(cfg[i]);
    check("midrst_q", 32'(q_o), 32'hFF);
    check("midrst_valid", 32'(valid_o), 32'd0);
    check("midrst_done", 32'(done_o), 32'd0);
    @(negedge clk) set_n = 1'b1;

    // Galois form
    sel = 1;
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    check_model("gal_start");
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    check("gal_c7", 32'(q_o), 32'hC7);
    check_model("gal_step0");
    period = 0;
    for (int unsigned k = 1; k < 255; k++) begin
      cycle(1'b1, 1'b0, 1'b0, 8'h00);
      check_model($sformatf("gal_run%0d", k));
      if (period == 0 && q_o == 8'hFF) period = k + 1;
    end
    check("gal_period", period, 32'd255);
    check("gal_done", 32'(done_o), 32'd1);

    // Load, lockup recovery, ld priority
    sel = 0;
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 1'b1, 8'h00);
    check("ld0_q", 32'(q_o), 32'hFF);
    check("ld0_lockup", 32'(lockup_o), 32'd1);
    check("ld0_valid", 32'(valid_o), 32'd0);
    check_model("ld0");
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    check("ld0_lockup_clear", 32'(lockup_o), 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 8'h5A);
    check("ld5a_q", 32'(q_o), 32'h5A);
    check("ld5a_valid", 32'(valid_o), 32'd0);
    check_model("ld5a");
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    check("idle_hold_q", 32'(q_o), 32'h5A);
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 1'b1, 8'h33);
    check("ld_wins_q", 32'(q_o), 32'h33);
    check("ld_wins_valid", 32'(valid_o), 32'd0);
    check_model("ld_wins");

    // Short run, NUM_PATTERNS = 4
    sel = 2;
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    distinct = 0;
    nvalid = 0;
    for (int k = 0; k < 5; k++) begin
      if (valid_o) begin
        nvalid++;
        if (!seen[q_o]) begin
          seen[q_o] = 1'b1;
          distinct++;
        end
      end
      cycle(en_pat[k], 1'b0, 1'b0, 8'h00);
      check_model($sformatf("short%0d", k));
    end
    check("short_valid_cycles", nvalid, 32'd5);
    check("short_distinct", distinct, 32'd4);
    check("short_done", 32'(done_o), 32'd1);
    frozen = q_o;
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    check("short_resume_q", 32'(q_o), 32'(frozen));
    check("short_resume_valid", 32'(valid_o), 32'd1);
    check("short_resume_done", 32'(done_o), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    check_model("short_resume_step");

    // Randomized traffic on all three configurations
    for (int unsigned s = 0; s < 3; s++) begin
      sel = s;
      for (int k = 0; k < 400; k++) begin
        logic [7:0] sd;
        sd = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
        cycle($urandom_range(0, 9) < 7, $urandom_range(0, 23) == 0, $urandom_range(0, 31) == 0, sd);
        check_model($sformatf("rnd%0d_%0d", s, k));
      end
    end

    // Package successor function against the reference
    for (int k = 0; k < 20; k++) begin
      rs = 32'($urandom_range(1, 255));
      check("pkg_fib", lfsr_next(rs, 32'hB8, 1'b0, 8), ref_step(cfg[0], rs));
      check("pkg_gal", lfsr_next(rs, 32'hB8, 1'b1, 8), ref_step(cfg[1], rs));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
